// File: rtl/ps2_scan_controller.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixes into {ext, brk, code} events,
// buffers them in a small FIFO and exposes STATUS/DATA registers with a level irq.
module ps2_scan_controller #(
    parameter int FIFO_DEPTH     = 4,
    parameter int PREFIX_TIMEOUT = 25_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_valid,
    input  logic [7:0] ps2_byte,
    output logic       dec_int_clear,
    input  logic       bus_rd,
    input  logic       bus_addr,
    output logic [7:0] bus_dout,
    output logic       irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(PREFIX_TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(PREFIX_TIMEOUT - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

    state_t          state_reg;
    logic [TW-1:0]   timer_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            ovf_reg;
    logic            dec_int_clear_reg;
    logic [7:0]      bus_dout_reg;
    logic [9:0]      mem [FIFO_DEPTH];

    logic            evt_push;
    logic            evt_ext;
    logic            evt_brk;
    logic            non_empty;
    logic            full;
    logic            pop;
    logic            push_ok;
    logic            ovf_set;
    logic            status_rd;
    logic [9:0]      head;
    logic [7:0]      status_byte;

    // Any byte other than a prefix completes an event, qualified by the current state.
    always_comb begin
        evt_push = 1'b0;
        evt_ext  = 1'b0;
        evt_brk  = 1'b0;
        if (ps2_valid && ps2_byte != 8'hE0 && ps2_byte != 8'hF0) begin
            evt_push = 1'b1;
            evt_ext  = (state_reg == S_E0) || (state_reg == S_E0F0);
            evt_brk  = (state_reg == S_F0) || (state_reg == S_E0F0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            timer_reg <= '0;
        end else if (ps2_valid) begin
            timer_reg <= '0;
            case (ps2_byte)
                8'hE0: state_reg <= S_E0;
                8'hF0: begin
                    if (state_reg == S_E0 || state_reg == S_E0F0)
                        state_reg <= S_E0F0;
                    else
                        state_reg <= S_F0;
                end
                default: state_reg <= S_IDLE;
            endcase
        end else if (state_reg != S_IDLE) begin
            // A stale prefix is abandoned silently.
            if (timer_reg == TIMER_LAST) begin
                state_reg <= S_IDLE;
                timer_reg <= '0;
            end else begin
                timer_reg <= timer_reg + 1'b1;
            end
        end
    end

    assign head        = mem[rd_ptr_reg];
    assign non_empty   = (count_reg != '0);
    assign full        = (count_reg == COUNT_FULL);
    assign pop         = bus_rd && bus_addr && non_empty;
    assign status_rd   = bus_rd && !bus_addr;
    assign push_ok     = evt_push && (!full || pop);
    assign ovf_set     = evt_push && full && !pop;
    assign status_byte = {non_empty, ovf_reg, non_empty ? head[9:8] : 2'b00, 4'(count_reg)};

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= {evt_ext, evt_brk, ps2_byte};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            count_reg         <= '0;
            ovf_reg           <= 1'b0;
            dec_int_clear_reg <= 1'b0;
            bus_dout_reg      <= 8'h00;
        end else begin
            dec_int_clear_reg <= ps2_valid;
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // A new overflow wins over the clear-on-read of the same cycle.
            ovf_reg <= ovf_set || (ovf_reg && !status_rd);
            if (bus_rd) begin
                if (bus_addr)
                    bus_dout_reg <= non_empty ? head[7:0] : 8'h00;
                else
                    bus_dout_reg <= status_byte;
            end
        end
    end

    assign dec_int_clear = dec_int_clear_reg;
    assign bus_dout      = bus_dout_reg;
    assign irq           = non_empty;

endmodule

// File: tb/tb_ps2_scan_controller.sv
// Scoreboard bench for ps2_scan_controller: expected events are queued as bytes
// are sent and popped against STATUS/DATA reads.
module tb_ps2_scan_controller;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_valid = 1'b0;
    logic [7:0] ps2_byte = 8'h00;
    logic       dec_int_clear;
    logic       bus_rd = 1'b0;
    logic       bus_addr = 1'b0;
    logic [7:0] bus_dout;
    logic       irq;

    int         checks = 0;
    int         errors = 0;
    int         clr_cnt = 0;
    logic [9:0] q[$];
    bit         ovf_exp = 1'b0;

    ps2_scan_controller #(.FIFO_DEPTH(DEPTH), .PREFIX_TIMEOUT(25_000)) dut (
        .clk(clk), .reset(reset), .ps2_valid(ps2_valid), .ps2_byte(ps2_byte),
        .dec_int_clear(dec_int_clear), .bus_rd(bus_rd), .bus_addr(bus_addr),
        .bus_dout(bus_dout), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dec_int_clear === 1'b1) clr_cnt++;

    function automatic logic [7:0] exp_status();
        logic [9:0] h;
        h = (q.size() != 0) ? q[0] : 10'h000;
        return {q.size() != 0, ovf_exp, h[9:8], 4'(q.size())};
    endfunction

    function automatic logic [7:0] model_pop();
        logic [9:0] e;
        if (q.size() == 0) return 8'h00;
        e = q.pop_front();
        return e[7:0];
    endfunction

    task automatic model_push(input logic [9:0] e);
        if (q.size() < DEPTH) q.push_back(e);
        else ovf_exp = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        ps2_valid = 1'b1;
        ps2_byte  = b;
        @(posedge clk); #1;
        ps2_valid = 1'b0;
        $display("tx byte %h", b);
    endtask

    task automatic rd(input logic a, output logic [7:0] d);
        bus_rd   = 1'b1;
        bus_addr = a;
        @(posedge clk); #1;
        bus_rd = 1'b0;
        d = bus_dout;
        $display("rd %s %h", a ? "DATA  " : "STATUS", d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b1; ps2_valid = 1'b1; ps2_byte = 8'h1C; bus_rd = 1'b1; bus_addr = 1'b1;
        idle(3);
        checks++; if (bus_dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", bus_dout); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
        checks++; if (dec_int_clear !== 1'b0) begin errors++; $display("FAIL reset_clr got %b want 0", dec_int_clear); end
        reset = 1'b0; ps2_valid = 1'b0; bus_rd = 1'b0;
        idle(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL post_reset_irq got %b want 0", irq); end
        checks++; if (dec_int_clear !== 1'b0) begin errors++; $display("FAIL post_reset_clr got %b want 0", dec_int_clear); end
        rd(1'b0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_status got %h want 00", d); end
    endtask

    task automatic test_single();
        logic [7:0] d, e;
        send(8'h1C); model_push(10'h01C);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL single_irq got %b want 1", irq); end
        e = exp_status(); ovf_exp = 1'b0; rd(1'b0, d);
        checks++; if (d !== e) begin errors++; $display("FAIL single_status got %h want %h", d, e); end
        checks++; if (d !== 8'h81) begin errors++; $display("FAIL single_status_lit got %h want 81", d); end
        e = model_pop(); rd(1'b1, d);
        checks++; if (d !== e) begin errors++; $display("FAIL single_data got %h want %h", d, e); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_drop got %b want 0", irq); end
        e = exp_status(); rd(1'b0, d);
        checks++; if (d !== e) begin errors++; $display("FAIL single_status_empty got %h want %h", d, e); end
    endtask

    task automatic test_ext_break();
        logic [7:0] d, e;
        int c0;
        c0 = clr_cnt;
        send(8'hE0); send(8'hF0); send(8'h75); model_push({2'b11, 8'h75});
        idle(1);
        checks++; if (clr_cnt - c0 != 3) begin errors++; $display("FAIL extbrk_clr_pulses got %0d want 3", clr_cnt - c0); end
        e = exp_status(); ovf_exp = 1'b0; rd(1'b0, d);
        checks++; if (d !== e) begin errors++; $display("FAIL extbrk_status got %h want %h", d, e); end
        checks++; if (d !== 8'hB1) begin errors++; $display("FAIL extbrk_status_lit got %h want B1", d); end
        e = model_pop(); rd(1'b1, d);
        checks++; if (d !== e) begin errors++; $display("FAIL extbrk_data got %h want %h", d, e); end
    endtask

    task automatic test_timeout();
        logic [7:0] d, e;
        send(8'hF0); send(8'h1C); model_push({2'b01, 8'h1C});
        e = exp_status(); ovf_exp = 1'b0; rd(1'b0, d);
        checks++; if (d !== e) begin errors++; $display("FAIL brk_status got %h want %h", d, e); end
        checks++; if (d !== 8'h91) begin errors++; $display("FAIL brk_status_lit got %h want 91", d); end
        send(8'hE0); idle(25_000); send(8'h1C); model_push(10'h01C);
        e = exp_status(); ovf_exp = 1'b0; rd(1'b0, d);
        checks++; if (d !== e) begin errors++; $display("FAIL timeout_status got %h want %h", d, e); end
        checks++; if (d[3:0] !== 4'd2) begin errors++; $display("FAIL timeout_count got %0d want 2", d[3:0]); end
        for (int i = 0; i < 2; i++) begin
            e = model_pop(); rd(1'b1, d);
            checks++; if (d !== e) begin errors++; $display("FAIL timeout_data%0d got %h want %h", i, d, e); end
        end
        // Just inside the window the prefix must still apply.
        send(8'hE0); idle(24_990); send(8'h74); model_push({2'b10, 8'h74});
        e = exp_status(); ovf_exp = 1'b0; rd(1'b0, d);
        checks++; if (d !== e) begin errors++; $display("FAIL near_timeout_status got %h want %h", d, e); end
        e = model_pop(); rd(1'b1, d);
        checks++; if (d !== e) begin errors++; $display("FAIL near_timeout_data got %h want %h", d, e); end
    endtask

    task automatic test_overflow();
        logic [7:0] d, e;
        int c0;
        c0 = clr_cnt;
        for (int i = 1; i <= 5; i++) begin
            ps2_valid = 1'b1; ps2_byte = 8'(i);
            model_push({2'b00, 8'(i)});
            @(posedge clk); #1;
            $display("tx byte %h", ps2_byte);
        end
        ps2_valid = 1'b0;
        idle(1);
        checks++; if (clr_cnt - c0 != 5) begin errors++; $display("FAIL b2b_clr_pulses got %0d want 5", clr_cnt - c0); end
        e = exp_status(); ovf_exp = 1'b0; rd(1'b0, d);
        checks++; if (d !== e) begin errors++; $display("FAIL ovf_status got %h want %h", d, e); end
        checks++; if (d !== 8'hC4) begin errors++; $display("FAIL ovf_status_lit got %h want C4", d); end
        e = exp_status(); rd(1'b0, d);
        checks++; if (d !== e) begin errors++; $display("FAIL ovf_cleared got %h want %h", d, e); end
        for (int i = 0; i < 4; i++) begin
            e = model_pop(); rd(1'b1, d);
            checks++; if (d !== e) begin errors++; $display("FAIL ovf_data%0d got %h want %h", i, d, e); end
        end
        e = exp_status(); rd(1'b0, d);
        checks++; if (d !== e) begin errors++; $display("FAIL ovf_drained got %h want %h", d, e); end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] d, e;
        for (int i = 0; i < 4; i++) begin
            send(8'h11 + 8'(i)); model_push({2'b00, 8'h11 + 8'(i)});
        end
        bus_rd = 1'b1; bus_addr = 1'b1; ps2_valid = 1'b1; ps2_byte = 8'h09;
        @(posedge clk); #1;
        bus_rd = 1'b0; ps2_valid = 1'b0; d = bus_dout;
        $display("rd DATA   %h with tx byte 09", d);
        e = model_pop(); model_push(10'h009);
        checks++; if (d !== e) begin errors++; $display("FAIL pp_data got %h want %h", d, e); end
        e = exp_status(); ovf_exp = 1'b0; rd(1'b0, d);
        checks++; if (d !== e) begin errors++; $display("FAIL pp_status got %h want %h", d, e); end
        for (int i = 0; i < 4; i++) begin
            e = model_pop(); rd(1'b1, d);
            checks++; if (d !== e) begin errors++; $display("FAIL pp_data%0d got %h want %h", i, d, e); end
        end
        checks++; if (d !== 8'h09) begin errors++; $display("FAIL pp_last got %h want 09", d); end
    endtask

    task automatic test_ovf_same_cycle();
        logic [7:0] d, e;
        for (int i = 0; i < 4; i++) begin
            send(8'h31 + 8'(i)); model_push({2'b00, 8'h31 + 8'(i)});
        end
        bus_rd = 1'b1; bus_addr = 1'b0; ps2_valid = 1'b1; ps2_byte = 8'h35;
        @(posedge clk); #1;
        bus_rd = 1'b0; ps2_valid = 1'b0; d = bus_dout;
        $display("rd STATUS %h with tx byte 35", d);
        e = exp_status(); ovf_exp = 1'b0; model_push(10'h035);
        checks++; if (d !== e) begin errors++; $display("FAIL sticky_pre got %h want %h", d, e); end
        e = exp_status(); ovf_exp = 1'b0; rd(1'b0, d);
        checks++; if (d !== e) begin errors++; $display("FAIL sticky_survive got %h want %h", d, e); end
        for (int i = 0; i < 4; i++) begin
            e = model_pop(); rd(1'b1, d);
            checks++; if (d !== e) begin errors++; $display("FAIL sticky_data%0d got %h want %h", i, d, e); end
        end
    endtask

    task automatic test_empty_read();
        logic [7:0] d, e;
        send(8'h5A); model_push(10'h05A);
        e = model_pop(); rd(1'b1, d);
        checks++; if (d !== e) begin errors++; $display("FAIL empty_pre_data got %h want %h", d, e); end
        e = model_pop(); rd(1'b1, d);
        checks++; if (d !== e) begin errors++; $display("FAIL empty_data got %h want %h", d, e); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL empty_irq got %b want 0", irq); end
        e = exp_status(); rd(1'b0, d);
        checks++; if (d !== e) begin errors++; $display("FAIL empty_status got %h want %h", d, e); end
    endtask

    task automatic test_reset_mid_prefix();
        logic [7:0] d, e;
        send(8'h22); model_push(10'h022);
        send(8'hE0);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        q.delete(); ovf_exp = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq got %b want 0", irq); end
        send(8'h1C); model_push(10'h01C);
        e = exp_status(); ovf_exp = 1'b0; rd(1'b0, d);
        checks++; if (d !== e) begin errors++; $display("FAIL midrst_status got %h want %h", d, e); end
        e = model_pop(); rd(1'b1, d);
        checks++; if (d !== e) begin errors++; $display("FAIL midrst_data got %h want %h", d, e); end
        e = exp_status(); rd(1'b0, d);
        checks++; if (d !== e) begin errors++; $display("FAIL midrst_empty got %h want %h", d, e); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ext_break();
        test_timeout();
        test_overflow();
        test_push_pop_full();
        test_ovf_same_cycle();
        test_empty_read();
        test_reset_mid_prefix();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
